uart_tx_arbiter: RTL and testbench

Shares one uart_tx byte transmitter between NumReq requesters, e.g. boot console, debug monitor and CPU MMIO port.
- Round-robin arbitration, with optional packet lock so a multi-byte message is not interleaved.
- Sequences the transmitter's dv/busy handshake: one byte per transaction, issued only when the transmitter is idle.
- Sits between the requesters and uart_tx in the UART subsystem.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  // Arbiter sequencing states: pick a requester, pulse dv, wait for the transmitter.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest requester set the round-robin helper can handle.
  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxIdxW = 5;

  // Round-robin pick: first set bit of mask at or after ptr, wrapping modulo n.
  // Scanning offsets from high to low leaves the smallest matching offset as the result.
  // Returns ptr when mask is empty; callers qualify with |mask.
  function automatic logic [MaxIdxW-1:0] rr_pick(
    input logic [MaxReq-1:0]  mask,
    input logic [MaxIdxW-1:0] ptr,
    input logic [MaxIdxW:0]   n
  );
    logic [MaxIdxW:0]   cand;
    logic [MaxIdxW-1:0] pick;
    pick = ptr;
    for (int i = int'(MaxReq) - 1; i >= 0; i--) begin
      if (i < int'(n)) begin
        cand = {1'b0, ptr} + (MaxIdxW + 1)'(i);
        if (cand >= n) cand = cand - n;
        if (mask[cand[MaxIdxW-1:0]]) pick = cand[MaxIdxW-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index of the first
// requester at or after the pointer.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx,
  output logic              found
);

  logic [MaxReq-1:0]  mask_ext;
  logic [MaxIdxW-1:0] pick;

  // Widen the request vector for the shared helper and decode its pick.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mask_ext             = '0;
    mask_ext[NumReq-1:0] = req;
    pick                 = rr_pick(mask_ext, MaxIdxW'(ptr), (MaxIdxW + 1)'(NumReq));
    idx                  = IdxW'(pick);
    found                = |req;
    grant                = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between NumReq requesters with
// round-robin arbitration and optional packet lock (bounded by MaxBurst).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned MaxBurst  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq-1:0]           en_mask_i,
  output logic                        tx_dv_o,
  output logic [DataWidth-1:0]        tx_data_o,
  input  logic                        tx_busy_i,
  output logic [NumReq-1:0]           grant_o,
  output logic                        active_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = ($clog2(MaxBurst + 1) < 1) ? 1 : $clog2(MaxBurst + 1);
  // Burst count value at which the current grant forces the lock to release.
  localparam logic [CntW-1:0] BurstLast = CntW'((MaxBurst == 0) ? 0 : MaxBurst - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q;
  logic                lock_q;
  logic [IdxW-1:0]     owner_q;
  logic [CntW-1:0]     cnt_q;
  logic [DataWidth-1:0] data_q;
  logic                dv_q;
  logic [NumReq-1:0]   grant_q;

  logic [NumReq-1:0]   owner_onehot;
  logic                owner_en;
  logic                lock_hold;
  logic [NumReq-1:0]   eligible;
  logic [NumReq-1:0]   pick_onehot;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_found;
  logic                take;
  logic                release_lock;
  logic [CntW-1:0]     cnt_base;
  logic [IdxW-1:0]     ptr_next;

  assign owner_onehot = {{(NumReq - 1){1'b0}}, 1'b1} << owner_q;
  assign owner_en     = en_mask_i[owner_q];
  // A lock only constrains arbitration while its owner is still enabled.
  assign lock_hold    = lock_q & owner_en;
  assign eligible     = req_valid_i & en_mask_i & (lock_hold ? owner_onehot : {NumReq{1'b1}});

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign cnt_base     = lock_hold ? cnt_q : '0;
  assign release_lock = req_last_i[pick_idx] | ((MaxBurst != 0) && (cnt_base == BurstLast));
  assign ptr_next     = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ARB;
    else         state_q <= state_d;
  end

  // Next-state decode and the one-cycle accept pulse; reset masks ready so no byte is consumed.
  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      ARB: begin
        if (rst_ni && !tx_busy_i && pick_found) begin
          take        = 1'b1;
          req_ready_o = pick_onehot;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = DRAIN;
      // Busy already low on the first DRAIN cycle is a transmitter protocol error;
      // falling straight back to ARB keeps the arbiter from hanging on it.
      DRAIN: if (!tx_busy_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Datapath, lock, burst count and pointer bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      grant_q <= '0;
    end else begin
      dv_q <= take;
      if (take) begin
        data_q  <= req_data_i[pick_idx*DataWidth +: DataWidth];
        grant_q <= pick_onehot;
        if (release_lock) begin
          lock_q <= 1'b0;
          cnt_q  <= '0;
          ptr_q  <= ptr_next;
        end else begin
          lock_q  <= 1'b1;
          owner_q <= pick_idx;
          cnt_q   <= cnt_base + 1'b1;
        end
      end else if (state_q == ARB && lock_q && !owner_en) begin
        lock_q  <= 1'b0;
        cnt_q   <= '0;
        grant_q <= '0;
      end else if (state_q == DRAIN && !tx_busy_i) begin
        grant_q <= lock_q ? owner_onehot : '0;
      end
    end
  end

  assign tx_dv_o   = dv_q;
  assign tx_data_o = data_q;
  assign grant_o   = grant_q;
  assign active_o  = (state_q != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: requester queues and a uart_tx busy
// model are stepped once per clock; dut_a uses MaxBurst=16, dut_b MaxBurst=2.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n, sel_b;
  logic [3:0]  req_valid, req_last, en_mask;
  logic [31:0] req_data;
  logic        tx_busy;

  logic [3:0]  ready_a, grant_a, ready_b, grant_b;
  logic        dv_a, active_a, dv_b, active_b;
  logic [7:0]  data_a, data_b;

  logic [3:0]  obs_ready, obs_grant;
  logic        obs_dv, obs_active;
  logic [7:0]  obs_data;

  uart_tx_arbiter #(.NumReq(4), .DataWidth(8), .MaxBurst(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready_a), .en_mask_i(en_mask), .tx_dv_o(dv_a),
    .tx_data_o(data_a), .tx_busy_i(tx_busy), .grant_o(grant_a), .active_o(active_a)
  );

  uart_tx_arbiter #(.NumReq(4), .DataWidth(8), .MaxBurst(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready_b), .en_mask_i(en_mask), .tx_dv_o(dv_b),
    .tx_data_o(data_b), .tx_busy_i(tx_busy), .grant_o(grant_b), .active_o(active_b)
  );

  assign obs_ready  = sel_b ? ready_b  : ready_a;
  assign obs_grant  = sel_b ? grant_b  : grant_a;
  assign obs_dv     = sel_b ? dv_b     : dv_a;
  assign obs_active = sel_b ? active_b : active_a;
  assign obs_data   = sel_b ? data_b   : data_a;

  int errors = 0;
  int checks = 0;

  typedef logic [8:0] ent_t;  // {last, byte}
  ent_t rq[4][$];
  int   tx_byte[$];
  int   tx_grant[$];
  int   acc_idx[$];
  int   busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample outputs 1ns later.
  task automatic step();
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0);
    for (int k = 0; k < 4; k++) begin
      req_valid[k] = (rq[k].size() > 0);
      if (rq[k].size() > 0) begin
        req_data[k*8 +: 8] = rq[k][0][7:0];
        req_last[k]        = rq[k][0][8];
      end else begin
        req_data[k*8 +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      if (obs_ready[k] && rq[k].size() > 0) begin
        acc_idx.push_back(k);
        void'(rq[k].pop_front());
      end
    end
    if (obs_dv) begin
      tx_byte.push_back(int'(obs_data));
      tx_grant.push_back(int'(obs_grant));
      busy_cnt = 4;
      tx_busy  = 1'b1;
    end
  endtask

  task automatic run_until_tx(input int n, input int budget);
    int c = 0;
    while (tx_byte.size() < n && c < budget) begin
      step();
      c++;
    end
    check("tx_count_within_budget", tx_byte.size(), n);
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while (obs_active && c < budget) begin
      step();
      c++;
    end
    check("return_to_arb_within_budget", obs_active, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; en_mask = 4'hF;
    tx_busy = 1'b0; busy_cnt = 0;
    for (int k = 0; k < 4; k++) rq[k].delete();
    tx_byte.delete(); tx_grant.delete(); acc_idx.delete();
    repeat (2) @(negedge clk);
    if (sel_b) rst_b_n = 1'b1;
    else       rst_a_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b2[5];
    int exp_g2[5];
    int exp_b3[4];
    int exp_a3[4];
    int exp_a4[6];

    // 1. Reset state, then a single byte from req0.
    sel_b = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; en_mask = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", obs_ready, 4'b0000);
    check("reset_dv", obs_dv, 1'b0);
    check("reset_data", obs_data, 8'h00);
    check("reset_grant", obs_grant, 4'b0000);
    check("reset_active", obs_active, 1'b0);
    en_mask = 4'hF;
    rst_a_n = 1'b1;
    rq[0].push_back(9'h155);
    step();
    check("t1_arb_ready", obs_ready, 4'b0001);
    check("t1_arb_dv", obs_dv, 1'b0);
    step();
    check("t1_issue_dv", obs_dv, 1'b1);
    check("t1_issue_data", obs_data, 8'h55);
    check("t1_issue_grant", obs_grant, 4'b0001);
    check("t1_issue_active", obs_active, 1'b1);
    step();
    check("t1_drain_dv", obs_dv, 1'b0);
    check("t1_drain_active", obs_active, 1'b1);
    run_until_idle(20);
    check("t1_idle_grant", obs_grant, 4'b0000);

    // 2. All four valid with last=1: strict rotation.
    do_reset();
    rq[0].push_back(9'h1A0); rq[0].push_back(9'h1A0);
    rq[1].push_back(9'h1A1); rq[2].push_back(9'h1A2); rq[3].push_back(9'h1A3);
    exp_b2 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    exp_g2 = '{1, 2, 4, 8, 1};
    run_until_tx(5, 200);
    for (int i = 0; i < 5 && i < tx_byte.size(); i++) begin
      check($sformatf("t2_byte%0d", i), tx_byte[i], exp_b2[i]);
      check($sformatf("t2_grant%0d", i), tx_grant[i], exp_g2[i]);
    end

    // 3. Three-byte packet from req0 is not interleaved with req1.
    do_reset();
    rq[0].push_back(9'h010); rq[0].push_back(9'h011); rq[0].push_back(9'h112);
    rq[1].push_back(9'h120);
    exp_b3 = '{32'h10, 32'h11, 32'h12, 32'h20};
    exp_a3 = '{0, 0, 0, 1};
    run_until_tx(4, 300);
    for (int i = 0; i < 4 && i < tx_byte.size(); i++) begin
      check($sformatf("t3_byte%0d", i), tx_byte[i], exp_b3[i]);
      check($sformatf("t3_accept%0d", i), acc_idx[i], exp_a3[i]);
    end

    // 4. MaxBurst=2 forces release of a packet that never ends.
    sel_b = 1'b1;
    do_reset();
    rq[0].push_back(9'h001); rq[0].push_back(9'h002);
    rq[0].push_back(9'h003); rq[0].push_back(9'h004);
    rq[1].push_back(9'h1B0); rq[1].push_back(9'h1B1);
    exp_a4 = '{0, 0, 1, 0, 0, 1};
    run_until_tx(6, 400);
    for (int i = 0; i < 6 && i < acc_idx.size(); i++)
      check($sformatf("t4_accept%0d", i), acc_idx[i], exp_a4[i]);
    sel_b = 1'b0;

    // 5. Lock holds against others, then drops when the owner is disabled.
    do_reset();
    rq[0].push_back(9'h050);
    run_until_tx(1, 50);
    run_until_idle(20);
    check("t5_locked_grant", obs_grant, 4'b0001);
    rq[2].push_back(9'h152);
    repeat (8) step();
    check("t5_lock_blocks_tx", tx_byte.size(), 1);
    check("t5_lock_blocks_accept", acc_idx.size(), 1);
    en_mask = 4'b1110;
    run_until_tx(2, 50);
    if (tx_byte.size() >= 2) begin
      check("t5_req2_byte", tx_byte[1], 32'h52);
      check("t5_req2_grant", tx_grant[1], 4);
    end
    run_until_idle(20);
    check("t5_unlocked_grant", obs_grant, 4'b0000);

    // 6. Reset during DRAIN aborts; a pending req3 byte survives it.
    do_reset();
    rq[0].push_back(9'h13C);
    run_until_tx(1, 50);
    step();
    check("t6_in_drain", obs_active, 1'b1);
    rst_a_n = 1'b0;
    busy_cnt = 0;
    tx_busy = 1'b0;
    #1;
    check("t6_rst_dv", obs_dv, 1'b0);
    check("t6_rst_grant", obs_grant, 4'b0000);
    check("t6_rst_active", obs_active, 1'b0);
    rq[3].push_back(9'h177);
    step();
    check("t6_rst_no_ready", obs_ready, 4'b0000);
    step();
    check("t6_rst_no_accept", acc_idx.size(), 1);
    rst_a_n = 1'b1;
    run_until_tx(2, 50);
    if (tx_byte.size() >= 2) begin
      check("t6_req3_byte", tx_byte[1], 32'h77);
      check("t6_req3_grant", tx_grant[1], 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
